oled_page_refresh: RTL and testbench

//  Parametrised SSD1306 sequencer driving the byte-level IIC driver: sends the init sequence, then per-page cursor

---
 rtl/oled_page_refresh_if.sv | 41 ++++
 rtl/oled_page_refresh.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_oled_page_refresh.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/oled_page_refresh_if.sv
// +--------------------------------------------------------------------------+
// | oled_page_refresh_if : host, framebuffer and IIC byte-driver bundle      |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface oled_page_refresh_if #(
  parameter int FB_AW = 10
);
  logic             start;
  logic             init_req;
  logic             mode;
  logic [7:0]       pattern;
  logic             fb_rd_en;
  logic [FB_AW-1:0] fb_addr;
  logic [7:0]       fb_rd_data;
  logic             iic_done;
  logic             iic_exec;
  logic             iic_w_ctrl;
  logic [7:0]       iic_w_data;
  logic             busy;
  logic             frame_done;
  logic             err;
  logic             init_done;

  // master is the sequencer, slave is the host/framebuffer/driver environment
  modport master (
    input  start, init_req, mode, pattern, fb_rd_data, iic_done,
    output fb_rd_en, fb_addr, iic_exec, iic_w_ctrl, iic_w_data,
           busy, frame_done, err, init_done
  );

  modport slave (
    output start, init_req, mode, pattern, fb_rd_data, iic_done,
    input  fb_rd_en, fb_addr, iic_exec, iic_w_ctrl, iic_w_data,
           busy, frame_done, err, init_done
  );
endinterface

`default_nettype wire

// File: rtl/oled_page_refresh.sv
// +--------------------------------------------------------------------------+
// | oled_page_refresh : SSD1306 init / page refresh sequencer for IIC driver |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module oled_page_refresh #(
  parameter int NUM_PAGES  = 8,
  parameter int NUM_COLS   = 128,
  parameter int COL_OFFSET = 0,
  parameter int TIMEOUT    = 4096,
  parameter int FB_AW      = 10
) (
  input  wire logic        iic_driver_clk,
  input  wire logic        sys_rst_n,
  oled_page_refresh_if.master bus
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_FETCH_WAIT, ST_LATCH, ST_ISSUE,
    ST_WAIT_LO, ST_WAIT_HI, ST_DONE, ST_ERR
  } state_t;

  typedef enum logic [1:0] {PH_INIT, PH_CURSOR, PH_DATA} phase_t;

  localparam int         WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [7:0] MUX_ARG   = 8'(NUM_PAGES * 8 - 1);
  localparam logic [7:0] COL_OFF   = 8'(COL_OFFSET);
  localparam logic [2:0] LAST_PAGE = 3'(NUM_PAGES - 1);
  localparam logic [6:0] LAST_COL  = 7'(NUM_COLS - 1);

  state_t           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [4:0]       init_idx_q, init_idx_d;
  logic [1:0]       cur_idx_q, cur_idx_d;
  logic [2:0]       page_q, page_d;
  logic [6:0]       col_q, col_d;
  logic             pend_q, pend_d;
  logic             mode_q, mode_d;
  logic [7:0]       pattern_q, pattern_d;
  logic [7:0]       fb_byte_q, fb_byte_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             err_q, err_d;
  logic             init_done_q, init_done_d;
  logic             exec_q, exec_d;
  logic             w_ctrl_q, w_ctrl_d;
  logic [7:0]       w_data_q, w_data_d;
  logic             fb_rd_en_q, fb_rd_en_d;
  logic [FB_AW-1:0] fb_addr_q, fb_addr_d;

  logic [7:0]       byte_w;
  logic             wd_expired_w;
  logic             go_err_w;
  logic             finish_w;

  function automatic logic [7:0] init_byte(input logic [4:0] idx);
    case (idx)
      5'd0:  init_byte = 8'hAE;   5'd1:  init_byte = 8'hD5;
      5'd2:  init_byte = 8'h80;   5'd3:  init_byte = 8'hA8;
      5'd4:  init_byte = MUX_ARG; 5'd5:  init_byte = 8'hD3;
      5'd6:  init_byte = 8'h00;   5'd7:  init_byte = 8'h40;
      5'd8:  init_byte = 8'hA1;   5'd9:  init_byte = 8'hC8;
      5'd10: init_byte = 8'hDA;   5'd11: init_byte = 8'h12;
      5'd12: init_byte = 8'h81;   5'd13: init_byte = 8'hCF;
      5'd14: init_byte = 8'hD9;   5'd15: init_byte = 8'hF1;
      5'd16: init_byte = 8'hDB;   5'd17: init_byte = 8'h30;
      5'd18: init_byte = 8'hA4;   5'd19: init_byte = 8'hA6;
      5'd20: init_byte = 8'h8D;   5'd21: init_byte = 8'h14;
      default: init_byte = 8'hAF;
    endcase
  endfunction

  always_comb begin
    byte_w = fb_byte_q;
    case (phase_q)
      PH_INIT:   byte_w = init_byte(init_idx_q);
      PH_CURSOR: begin
        case (cur_idx_q)
          2'd0:    byte_w = 8'hB0 | {5'd0, page_q};
          2'd1:    byte_w = 8'h10 | {4'd0, COL_OFF[7:4]};
          default: byte_w = {4'd0, COL_OFF[3:0]};
        endcase
      end
      default:   byte_w = mode_q ? (page_q[0] ? pattern_q : ~pattern_q) : fb_byte_q;
    endcase
  end

  assign wd_expired_w = (wdog_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    init_idx_d   = init_idx_q;
    cur_idx_d    = cur_idx_q;
    page_d       = page_q;
    col_d        = col_q;
    pend_d       = pend_q;
    mode_d       = mode_q;
    pattern_d    = pattern_q;
    fb_byte_d    = fb_byte_q;
    wdog_d       = wdog_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    err_d        = err_q;
    init_done_d  = init_done_q;
    exec_d       = 1'b0;
    w_ctrl_d     = w_ctrl_q;
    w_data_d     = w_data_q;
    fb_rd_en_d   = 1'b0;
    fb_addr_d    = fb_addr_q;
    go_err_w     = 1'b0;
    finish_w     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start || bus.init_req) begin
          busy_d     = 1'b1;
          err_d      = 1'b0;
          wdog_d     = '0;
          init_idx_d = '0;
          cur_idx_d  = '0;
          page_d     = '0;
          col_d      = '0;
          state_d    = ST_ISSUE;
          if (bus.start) begin
            mode_d    = bus.mode;
            pattern_d = bus.pattern;
          end
          // a start alongside init_req (or before first init) refreshes after init
          if (bus.init_req || !init_done_q) begin
            phase_d = PH_INIT;
            pend_d  = bus.start;
          end else begin
            phase_d = PH_CURSOR;
            pend_d  = 1'b0;
          end
        end
      end
      ST_FETCH: begin
        fb_rd_en_d = 1'b1;
        fb_addr_d  = FB_AW'(int'(page_q) * NUM_COLS + int'(col_q));
        state_d    = ST_FETCH_WAIT;
      end
      ST_FETCH_WAIT: state_d = ST_LATCH;
      ST_LATCH: begin
        fb_byte_d = bus.fb_rd_data;
        wdog_d    = '0;
        state_d   = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (bus.iic_done) begin
          exec_d   = 1'b1;
          w_ctrl_d = (phase_q != PH_DATA);
          w_data_d = byte_w;
          wdog_d   = '0;
          state_d  = ST_WAIT_LO;
        end else if (wd_expired_w) go_err_w = 1'b1;
        else wdog_d = wdog_q + 1'b1;
      end
      ST_WAIT_LO: begin
        if (!bus.iic_done) begin
          wdog_d  = '0;
          state_d = ST_WAIT_HI;
        end else if (wd_expired_w) go_err_w = 1'b1;
        else wdog_d = wdog_q + 1'b1;
      end
      ST_WAIT_HI: begin
        if (bus.iic_done) begin
          wdog_d  = '0;
          state_d = ST_ISSUE;
          case (phase_q)
            PH_INIT: begin
              if (init_idx_q == 5'd22) begin
                init_done_d = 1'b1;
                if (pend_q) phase_d = PH_CURSOR;
                else        finish_w = 1'b1;
              end else init_idx_d = init_idx_q + 5'd1;
            end
            PH_CURSOR: begin
              if (cur_idx_q == 2'd2) begin
                phase_d = PH_DATA;
                col_d   = '0;
                if (!mode_q) state_d = ST_FETCH;
              end else cur_idx_d = cur_idx_q + 2'd1;
            end
            default: begin
              if (col_q == LAST_COL) begin
                if (page_q == LAST_PAGE) finish_w = 1'b1;
                else begin
                  page_d    = page_q + 3'd1;
                  cur_idx_d = '0;
                  phase_d   = PH_CURSOR;
                end
              end else begin
                col_d = col_q + 7'd1;
                if (!mode_q) state_d = ST_FETCH;
              end
            end
          endcase
        end else if (wd_expired_w) go_err_w = 1'b1;
        else wdog_d = wdog_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish_w) begin
      state_d      = ST_DONE;
      frame_done_d = 1'b1;
      busy_d       = 1'b0;
    end
    if (go_err_w) begin
      state_d = ST_ERR;
      err_d   = 1'b1;
      busy_d  = 1'b0;
      exec_d  = 1'b0;
      if (phase_q == PH_INIT) init_done_d = 1'b0;
    end
  end

  always_ff @(posedge iic_driver_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= PH_INIT;
      init_idx_q   <= '0;
      cur_idx_q    <= '0;
      page_q       <= '0;
      col_q        <= '0;
      pend_q       <= 1'b0;
      mode_q       <= 1'b0;
      pattern_q    <= '0;
      fb_byte_q    <= '0;
      wdog_q       <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      init_done_q  <= 1'b0;
      exec_q       <= 1'b0;
      w_ctrl_q     <= 1'b1;
      w_data_q     <= '0;
      fb_rd_en_q   <= 1'b0;
      fb_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      init_idx_q   <= init_idx_d;
      cur_idx_q    <= cur_idx_d;
      page_q       <= page_d;
      col_q        <= col_d;
      pend_q       <= pend_d;
      mode_q       <= mode_d;
      pattern_q    <= pattern_d;
      fb_byte_q    <= fb_byte_d;
      wdog_q       <= wdog_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      init_done_q  <= init_done_d;
      exec_q       <= exec_d;
      w_ctrl_q     <= w_ctrl_d;
      w_data_q     <= w_data_d;
      fb_rd_en_q   <= fb_rd_en_d;
      fb_addr_q    <= fb_addr_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;
  assign bus.err        = err_q;
  assign bus.init_done  = init_done_q;
  assign bus.iic_exec   = exec_q;
  assign bus.iic_w_ctrl = w_ctrl_q;
  assign bus.iic_w_data = w_data_q;
  assign bus.fb_rd_en   = fb_rd_en_q;
  assign bus.fb_addr    = fb_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_oled_page_refresh.sv
// +--------------------------------------------------------------------------+
// | tb_oled_page_refresh : full-size and reduced sequencer against a model   |
// | Revision 1.0 - initial release                                           |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_oled_page_refresh;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oled_page_refresh_if #(.FB_AW(10)) ifa();
  oled_page_refresh_if #(.FB_AW(3))  ifb();

  oled_page_refresh #(.NUM_PAGES(8), .NUM_COLS(128), .COL_OFFSET(0), .TIMEOUT(4096), .FB_AW(10))
    u_a (.iic_driver_clk(clk), .sys_rst_n(rst_n), .bus(ifa));
  oled_page_refresh #(.NUM_PAGES(2), .NUM_COLS(4), .COL_OFFSET('h23), .TIMEOUT(64), .FB_AW(3))
    u_b (.iic_driver_clk(clk), .sys_rst_n(rst_n), .bus(ifb));

  int vectors = 0, miscompares = 0;
  int fd_a = 0, fd_b = 0, viol_a = 0, viol_b = 0;
  logic [8:0] qa[$], qb[$], exp_q[$], obs_q[$];
  logic [2:0] aq[$];
  logic [7:0] mem_b [8];
  logic [4:0] cnt_a, cnt_b;
  bit stuck_b = 1'b0;

  assign ifa.fb_rd_data = 8'h00;

  // IIC driver models: busy (iic_done low) for a while after each exec
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin ifa.iic_done <= 1'b1; cnt_a <= '0; end
    else if (cnt_a != 0) begin cnt_a <= cnt_a - 1; if (cnt_a == 1) ifa.iic_done <= 1'b1; end
    else if (ifa.iic_exec) begin ifa.iic_done <= 1'b0; cnt_a <= 5'd10; end
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin ifb.iic_done <= 1'b1; cnt_b <= '0; end
    else if (cnt_b != 0) begin cnt_b <= cnt_b - 1; if (cnt_b == 1) ifb.iic_done <= 1'b1; end
    else if (ifb.iic_exec && !stuck_b) begin ifb.iic_done <= 1'b0; cnt_b <= 5'($urandom_range(6, 1)); end
  end
  always @(posedge clk) if (ifb.fb_rd_en) ifb.fb_rd_data <= mem_b[ifb.fb_addr];

  always @(posedge clk) begin
    if (rst_n) begin
      if (ifa.iic_exec) begin
        qa.push_back({ifa.iic_w_ctrl, ifa.iic_w_data});
        if (cnt_a != 0 || !ifa.iic_done) viol_a++;
      end
      if (ifb.iic_exec) begin
        qb.push_back({ifb.iic_w_ctrl, ifb.iic_w_data});
        if (cnt_b != 0 || !ifb.iic_done) viol_b++;
      end
      if (ifb.fb_rd_en)   aq.push_back(ifb.fb_addr);
      if (ifa.frame_done) fd_a++;
      if (ifb.frame_done) fd_b++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Expected byte stream of one request, derived from the panel command set
  task automatic model(input bit with_init, input bit refresh, input int np, input int nc,
                       input int off, input bit md, input logic [7:0] pat);
    logic [7:0] tbl [23];
    tbl = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h00, 8'hD3, 8'h00, 8'h40, 8'hA1, 8'hC8, 8'hDA, 8'h12,
            8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h30, 8'hA4, 8'hA6, 8'h8D, 8'h14, 8'hAF};
    tbl[4] = 8'(np * 8 - 1);
    exp_q.delete();
    if (with_init) foreach (tbl[i]) exp_q.push_back({1'b1, tbl[i]});
    if (refresh) begin
      for (int p = 0; p < np; p++) begin
        exp_q.push_back({1'b1, 8'(8'hB0 + p)});
        exp_q.push_back({1'b1, 8'(8'h10 + off / 16)});
        exp_q.push_back({1'b1, 8'(off % 16)});
        for (int c = 0; c < nc; c++)
          exp_q.push_back({1'b0, md ? ((p % 2 == 1) ? pat : ~pat) : mem_b[p * nc + c]});
      end
    end
  endtask

  task automatic cmp(input string tag);
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  task automatic req(input bit is_b, input bit st, input bit ir, input bit md, input logic [7:0] pat);
    @(negedge clk);
    if (is_b) begin ifb.start = st; ifb.init_req = ir; ifb.mode = md; ifb.pattern = pat; end
    else      begin ifa.start = st; ifa.init_req = ir; ifa.mode = md; ifa.pattern = pat; end
    @(negedge clk);
    ifa.start = 1'b0; ifa.init_req = 1'b0; ifb.start = 1'b0; ifb.init_req = 1'b0;
  endtask

  task automatic wait_idle(input bit is_b, input int budget, input string tag);
    int n = 0;
    while ((is_b ? ifb.busy : ifa.busy) && n < budget) begin @(negedge clk); n++; end
    chk({tag, "_in_time"}, 32'(n < budget), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_bytes(input bit is_b, input int cnt, input int budget, input string tag);
    int n = 0;
    while ((is_b ? qb.size() : qa.size()) < cnt && n < budget) begin @(negedge clk); n++; end
    chk({tag, "_in_time"}, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_err(input int budget, output int n);
    n = 0;
    while (!ifb.err && n < budget) begin @(negedge clk); n++; end
  endtask

  initial begin
    logic [7:0] pat;
    int f0, n;
    ifa.start = 0; ifa.init_req = 0; ifa.mode = 0; ifa.pattern = 0;
    ifb.start = 0; ifb.init_req = 0; ifb.mode = 0; ifb.pattern = 0;
    foreach (mem_b[i]) mem_b[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", ifa.busy, 0);         chk("rst_exec", ifa.iic_exec, 0);
    chk("rst_wctrl", ifa.iic_w_ctrl, 1);  chk("rst_wdata", ifa.iic_w_data, 0);
    chk("rst_initdone", ifa.init_done, 0); chk("rst_err", ifa.err, 0);
    chk("rst_fdone", ifa.frame_done, 0);  chk("rst_rden", ifa.fb_rd_en, 0);
    chk("rst_addr", ifa.fb_addr, 0);      chk("rst_b_wctrl", ifb.iic_w_ctrl, 1);

    // full-size frame with init, pattern F0
    qa.delete(); f0 = fd_a;
    req(0, 1, 0, 1, 8'hF0);
    wait_idle(0, 25000, "a_frame1");
    obs_q = qa; model(1, 1, 8, 128, 0, 1, 8'hF0); cmp("a_frame1");
    chk("a_frame1_fdone", fd_a - f0, 1); chk("a_frame1_busy", ifa.busy, 0);
    chk("a_frame1_initdone", ifa.init_done, 1);

    // refresh only, with ignored requests while busy
    pat = 8'($urandom); qa.delete(); f0 = fd_a;
    req(0, 1, 0, 1, pat);
    repeat (50) @(negedge clk);
    req(0, 1, 1, 0, ~pat);
    wait_idle(0, 25000, "a_frame2");
    obs_q = qa;
    chk("a_frame2_first", obs_q.size() > 0 ? obs_q[0] : 9'h0, 9'h1B0);
    model(0, 1, 8, 128, 0, 1, pat); cmp("a_frame2");
    chk("a_frame2_fdone", fd_a - f0, 1); chk("a_frame2_busy", ifa.busy, 0);
    chk("a_protocol", viol_a, 0);

    // reduced instance: start+init_req together, framebuffer mode
    qb.delete(); aq.delete(); f0 = fd_b;
    req(1, 1, 1, 0, 8'h00);
    wait_idle(1, 5000, "b_frame1");
    obs_q = qb; model(1, 1, 2, 4, 'h23, 0, 8'h00); cmp("b_frame1");
    chk("b_frame1_fdone", fd_b - f0, 1);
    chk("b_addr_count", aq.size(), 8);
    foreach (aq[i]) chk($sformatf("b_addr%0d", i), aq[i], i);

    foreach (mem_b[i]) mem_b[i] = 8'($urandom);
    qb.delete(); f0 = fd_b;
    req(1, 1, 0, 0, 8'h00);
    repeat (5) @(negedge clk);
    req(1, 1, 1, 1, 8'h55);
    wait_idle(1, 5000, "b_frame2");
    obs_q = qb; model(0, 1, 2, 4, 'h23, 0, 8'h00); cmp("b_frame2");
    chk("b_frame2_fdone", fd_b - f0, 1); chk("b_frame2_busy", ifb.busy, 0);

    qb.delete(); f0 = fd_b;
    req(1, 0, 1, 0, 8'h00);
    wait_idle(1, 5000, "b_initonly");
    obs_q = qb; model(1, 0, 2, 4, 'h23, 0, 8'h00); cmp("b_initonly");
    chk("b_initonly_fdone", fd_b - f0, 1); chk("b_initonly_initdone", ifb.init_done, 1);

    pat = 8'($urandom); qb.delete();
    req(1, 1, 0, 1, pat);
    wait_idle(1, 5000, "b_pattern");
    obs_q = qb; model(0, 1, 2, 4, 'h23, 1, pat); cmp("b_pattern");

    // driver never drops iic_done: watchdog fires during cursor phase
    stuck_b = 1'b1; qb.delete(); f0 = fd_b;
    req(1, 1, 0, 1, pat);
    wait_bytes(1, 1, 100, "b_to_exec");
    wait_err(200, n);
    chk("b_to_window", 32'(n >= 58 && n <= 70), 1);
    chk("b_to_err", ifb.err, 1); chk("b_to_busy", ifb.busy, 0);
    chk("b_to_initdone", ifb.init_done, 1);
    repeat (20) @(negedge clk);
    chk("b_to_no_exec", qb.size(), 1); chk("b_to_no_fdone", fd_b - f0, 0);
    chk("b_to_err_sticky", ifb.err, 1);
    stuck_b = 1'b0; pat = 8'($urandom); qb.delete();
    req(1, 1, 0, 1, pat);
    chk("b_err_cleared", ifb.err, 0);
    wait_idle(1, 5000, "b_recover");
    obs_q = qb; model(0, 1, 2, 4, 'h23, 1, pat); cmp("b_recover");

    // watchdog during init clears init_done; next start reruns init
    stuck_b = 1'b1;
    req(1, 0, 1, 0, 8'h00);
    wait_err(300, n);
    chk("b_initto_err", ifb.err, 1); chk("b_initto_initdone", ifb.init_done, 0);
    repeat (3) @(negedge clk);
    stuck_b = 1'b0; qb.delete();
    req(1, 1, 0, 0, 8'h00);
    wait_idle(1, 5000, "b_reinit");
    obs_q = qb; model(1, 1, 2, 4, 'h23, 0, 8'h00); cmp("b_reinit");
    chk("b_protocol", viol_b, 0);

    // asynchronous reset in page 3 data of the full-size instance
    qa.delete();
    req(0, 1, 0, 1, 8'h3C);
    wait_bytes(0, 3 * 131 + 10, 25000, "a_page3");
    chk("a_page3_cursor", qa.size() > 393 ? qa[393] : 9'h0, 9'h1B3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", ifa.busy, 0);          chk("arst_exec", ifa.iic_exec, 0);
    chk("arst_wctrl", ifa.iic_w_ctrl, 1);   chk("arst_wdata", ifa.iic_w_data, 0);
    chk("arst_initdone", ifa.init_done, 0); chk("arst_fdone", ifa.frame_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    qa.delete();
    req(0, 1, 0, 1, 8'h3C);
    wait_bytes(0, 23, 1000, "a_reinit");
    obs_q = qa[0:22]; model(1, 0, 8, 128, 0, 1, 8'h3C); cmp("a_reinit");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

`default_nettype wire
